// File: rtl/shift_left_iter_if.sv
// Request/result handshake bundle for shift_left_iter.
// The o_overflow signal only exists when SHL_OVF_EN is defined.
interface shift_left_iter_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [31:0]      i_shamt;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
`ifdef SHL_OVF_EN
  logic             o_overflow;
`endif

`ifdef SHL_OVF_EN
  modport master (
    output i_valid, i_data, i_shamt, i_ready,
    input  o_ready, o_valid, o_data, o_overflow
  );
  modport slave (
    input  i_valid, i_data, i_shamt, i_ready,
    output o_ready, o_valid, o_data, o_overflow
  );
`else
  modport master (
    output i_valid, i_data, i_shamt, i_ready,
    input  o_ready, o_valid, o_data
  );
  modport slave (
    input  i_valid, i_data, i_shamt, i_ready,
    output o_ready, o_valid, o_data
  );
`endif
endinterface

// File: rtl/shift_left_iter.sv
// Multi-cycle logical left shifter: shifts up to STEP positions per clock.
// Optional feature macro: SHL_OVF_EN adds the ovf register and o_overflow,
// flagging any 1 bit shifted out past the MSB.
module shift_left_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  shift_left_iter_if.slave  bus
);

  // One extra bit so the remaining count can hold WIDTH itself.
  localparam int               REM_W   = $clog2(WIDTH) + 1;
  localparam logic [REM_W-1:0] WIDTH_R = REM_W'(WIDTH);
  localparam logic [REM_W-1:0] STEP_R  = REM_W'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] amt;
  logic [REM_W-1:0] n;
`ifdef SHL_OVF_EN
  logic             ovf_q, ovf_d;
  logic [2*WIDTH-1:0] ext;
`endif

  // Any upper amount bit set means "shift everything out", so clamp to WIDTH.
  always_comb begin
    amt = (bus.i_shamt >= 32'(WIDTH)) ? WIDTH_R : bus.i_shamt[REM_W-1:0];
  end

  // Datapath: load on accept, then peel off min(rem, STEP) positions per cycle.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    n      = '0;
`ifdef SHL_OVF_EN
    ovf_d  = ovf_q;
    ext    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          data_d = bus.i_data;
          rem_d  = amt;
`ifdef SHL_OVF_EN
          ovf_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        n     = (rem_q < STEP_R) ? rem_q : STEP_R;
        rem_d = rem_q - n;
`ifdef SHL_OVF_EN
        // Upper half of the widened shift collects the bits leaving the MSB.
        ext    = {{WIDTH{1'b0}}, data_q} << n;
        data_d = ext[WIDTH-1:0];
        ovf_d  = ovf_q | (|ext[2*WIDTH-1:WIDTH]);
`else
        data_d = data_q << n;
`endif
      end
      default: begin
      end
    endcase
  end

  // Next-state logic; SHIFT finishes when this cycle consumes the remainder.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = (amt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_q <= STEP_R) state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and working registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
`ifdef SHL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
`ifdef SHL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs decode registered state only; no input-to-output path.
  always_comb begin
    bus.o_ready    = (state_q == IDLE);
    bus.o_valid    = (state_q == DONE);
    bus.o_data     = data_q;
`ifdef SHL_OVF_EN
    bus.o_overflow = ovf_q;
`endif
  end

endmodule

// File: tb/tb_shift_left_iter.sv
// Self-checking bench for shift_left_iter (WIDTH=32, STEP=4).
module tb_shift_left_iter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  shift_left_iter_if #(.WIDTH(WIDTH)) bus ();

  shift_left_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result of shifting by the clamped amount, overflow as any
  // nonzero bit pushed above bit WIDTH-1, latency 1 + ceil(k/STEP).
  function automatic void model(input logic [31:0] d, input logic [31:0] s,
                                output logic [31:0] r, output logic o, output int lat);
    logic [63:0] e;
    int k;
    k   = (s >= 32'(WIDTH)) ? WIDTH : int'(s);
    e   = {32'b0, d} << k;
    r   = e[31:0];
    o   = |e[63:32];
    lat = 1 + (k + STEP - 1) / STEP;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_req(input logic [31:0] d, input logic [31:0] s,
                         input int hold, input string tag);
    logic [31:0] er;
    logic        eo;
    int          el;
    int          edges;
    model(d, s, er, eo, el);
    chk({tag, " ready_in_idle"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_shamt = s;
    tick();
    bus.i_valid = 1'b0;
    bus.i_data  = $urandom;
    bus.i_shamt = $urandom;
    edges = 1;
    while (!bus.o_valid && edges < 64) begin
      tick();
      edges++;
    end
    chk({tag, " latency"}, 64'(edges), 64'(el));
    chk({tag, " data"}, 64'(bus.o_data), 64'(er));
`ifdef SHL_OVF_EN
    chk({tag, " ovf"}, 64'(bus.o_overflow), 64'(eo));
`endif
    chk({tag, " not_ready_in_done"}, 64'(bus.o_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = ~d;
      bus.i_shamt = 32'd0;
      tick();
      chk({tag, " hold_valid"}, 64'(bus.o_valid), 64'd1);
      chk({tag, " hold_data"}, 64'(bus.o_data), 64'(er));
      chk({tag, " hold_not_ready"}, 64'(bus.o_ready), 64'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk({tag, " released_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, " released_ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    bus.i_shamt = '0;
    tick();
    tick();
    chk("reset o_valid", 64'(bus.o_valid), 64'd0);
    chk("reset o_ready", 64'(bus.o_ready), 64'd1);
    chk("reset o_data", 64'(bus.o_data), 64'd0);
`ifdef SHL_OVF_EN
    chk("reset ovf", 64'(bus.o_overflow), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a long shift discards the operation.
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hFFFF_FFFF;
    bus.i_shamt = 32'd31;
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("midshift busy", 64'(bus.o_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst o_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst o_ready", 64'(bus.o_ready), 64'd1);
    chk("midrst o_data", 64'(bus.o_data), 64'd0);
`ifdef SHL_OVF_EN
    chk("midrst ovf", 64'(bus.o_overflow), 64'd0);
`endif
    run_req(32'h0000_0003, 32'd7, 0, "after_reset");

    // Directed cases.
    run_req(32'h0000_0001, 32'd0, 0, "shamt0");
    run_req(32'h8000_0001, 32'd5, 0, "shamt5_ovf");
    run_req(32'hFFFF_FFFF, 32'h0000_0100, 0, "upper_bit");
    run_req(32'h0000_0000, 32'h8000_0000, 0, "zero_big");
    run_req(32'h1234_5678, 32'd4, 10, "held_done");
    run_req(32'h0000_0001, 32'd31, 0, "b2b_31");
    run_req(32'h0000_0001, 32'd1, 0, "b2b_1");
    run_req(32'hA5A5_A5A5, 32'd32, 0, "exact_width");
    run_req(32'h0000_FFFF, 32'd16, 1, "exact_step_mult");

    // Randomized requests across small, boundary and huge shift amounts.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] d;
      logic [31:0] s;
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       s = 32'($urandom_range(0, 40));
        1:       s = 32'($urandom_range(28, 34));
        default: s = $urandom;
      endcase
      run_req(d, s, $urandom_range(0, 3), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
